alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_iter_muldiv.sv | 105 ++++++++++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - Sel opcode encodings (4-bit, matches the existing datapath encoding)
//   - FSM state enum used by alu_seq and exposed on its debug port
package alu_pkg;

    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: shared iterative multiply / restoring-divide datapath.
// One operand bit is processed per cycle for WIDTH cycles after start.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      load operands and begin (ignored result of any prior run)
//   mode_i       0 = multiply (low WIDTH bits), 1 = unsigned divide (quotient)
//   a_i, b_i     operands captured on start_i (a = multiplicand/dividend)
//   done_o       high during the final iteration cycle
//   result_o     value the final iteration produces; valid when done_o is high
module alu_iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // acc: product (MUL) or partial remainder (DIV)
    // opa: shifting multiplicand (MUL) or fixed divisor (DIV)
    // opb: shifting multiplier (MUL) or dividend shifting out / quotient shifting in (DIV)
    logic             busy_q, busy_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] acc_q,  acc_d;
    logic [WIDTH-1:0] opa_q,  opa_d;
    logic [WIDTH-1:0] opb_q,  opb_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        busy_d  = busy_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        // Restoring-divide trial: bring in the next dividend bit, try subtracting.
        shifted = {acc_q, opb_q[WIDTH-1]};
        diff    = shifted - {1'b0, opa_q};

        if (start_i) begin
            busy_d = 1'b1;
            mode_d = mode_i;
            cnt_d  = '0;
            acc_d  = '0;
            opa_d  = mode_i ? b_i : a_i;
            opb_d  = mode_i ? a_i : b_i;
        end else if (busy_q) begin
            if (!mode_q) begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opa_q;
                end
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end else begin
                if (shifted >= {1'b0, opa_q}) begin
                    acc_d = diff[WIDTH-1:0];
                    opb_d = {opb_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    opb_d = {opb_q[WIDTH-2:0], 1'b0};
                end
            end
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end

        // The top loads its result register on the same edge as the last
        // iteration, so it takes the next-state value rather than the register.
        result_o = mode_q ? opb_d : acc_d;
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes and registered outputs.
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high; an output transfer happens on a rising edge where
// out_valid and out_ready are both high. Neither side may withdraw early:
// in_valid is held until in_ready, Res/flags hold until out_ready.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready high only in IDLE)
//   A, B, Sel          unsigned operands and 4-bit operation select
//   out_valid/out_ready output handshake (out_valid high only in DONE)
//   Res                registered result
//   zero_flag          registered, Res == 0
//   div_by_zero        registered, completed op was DIV with B == 0
//   dbg_state_o        current FSM state
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Res,
    output logic             zero_flag,
    output logic             div_by_zero,
    output state_e           dbg_state_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zf_q, zf_d;
    logic             dbz_q, dbz_d;

    logic             md_start;
    logic             md_mode;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [WIDTH-1:0] simple_res;
    logic             b_is_zero;

    function automatic logic [WIDTH-1:0] simple_op(input logic [3:0] sel,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (sel)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign b_is_zero  = (B == '0);
    assign simple_res = simple_op(Sel, A, B);
    assign md_start   = (state_q == IDLE) && in_valid &&
                        ((Sel == OP_MUL) || ((Sel == OP_DIV) && !b_is_zero));
    assign md_mode    = (Sel == OP_DIV);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .mode_i   (md_mode),
        .a_i      (A),
        .b_i      (B),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            zf_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zf_d    = zf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (Sel == OP_MUL) begin
                        state_d = MUL;
                    end else if ((Sel == OP_DIV) && !b_is_zero) begin
                        state_d = DIV;
                    end else if (Sel == OP_DIV) begin
                        state_d = DONE;
                        res_d   = '1;
                        zf_d    = 1'b0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                        res_d   = simple_res;
                        zf_d    = (simple_res == '0);
                        dbz_d   = 1'b0;
                    end
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    state_d = DONE;
                    res_d   = md_result;
                    zf_d    = (md_result == '0);
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign Res         = res_q;
    assign zero_flag   = zf_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Res;
    logic         zero_flag;
    logic         div_by_zero;
    state_e       dbg_state;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .Sel         (Sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Res         (Res),
        .zero_flag   (zero_flag),
        .div_by_zero (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic from the operation table.
    // lat = cycles from the accept edge to the first edge after which out_valid is seen.
    task automatic model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic zf, output logic dbz, output int lat);
        logic [63:0] p;
        dbz = 1'b0;
        lat = 1;
        p   = '0;
        case (s)
            4'd1: r = a + b;
            4'd2: r = a - b;
            4'd3: begin p = 64'(a) * 64'(b); r = p[W-1:0]; lat = W + 1; end
            4'd4: begin
                if (b == 0) begin r = '1; dbz = 1'b1; end
                else begin r = a / b; lat = W + 1; end
            end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = ~(a | b);
            4'd8: r = (a < b) ? 1 : 0;
            4'd9: r = a ^ b;
            default: r = '0;
        endcase
        zf = (r == 0);
    endtask

    // ---------------- driver ----------------
    // Issue one op, scramble inputs after accept, wait (bounded) for out_valid
    // while toggling out_ready randomly, then compare and drain.
    task automatic run_check(input string name, input logic [3:0] s, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp_res,
                             input logic exp_zf, input logic exp_dbz, input int exp_lat);
        int lat;
        @(negedge clk);
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
        A = a; B = b; Sel = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; Sel = 4'($urandom_range(0, 15));
        lat = 1;
        while (!out_valid && lat < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        check({name, ".Res"}, 64'(Res), 64'(exp_res));
        check({name, ".zero_flag"}, 64'(zero_flag), 64'(exp_zf));
        check({name, ".div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ".drain"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    typedef struct {
        string        name;
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zf;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [W-1:0] r;
        logic         zf;
        logic         dbz;
        int           lat;
        logic [3:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0]  = '{"add_wrap",  4'b0001, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b1, 1'b0, 1};
        vecs[1]  = '{"mul_big",   4'b0011, 32'h0001_0000, 32'h0001_0001,  32'h0001_0000,  1'b0, 1'b0, 33};
        vecs[2]  = '{"mul_7x6",   4'b0011, 32'd7,         32'd6,          32'd42,         1'b0, 1'b0, 33};
        vecs[3]  = '{"div_100_7", 4'b0100, 32'd100,       32'd7,          32'd14,         1'b0, 1'b0, 33};
        vecs[4]  = '{"div_zero",  4'b0100, 32'd100,       32'd0,          32'hFFFF_FFFF,  1'b0, 1'b1, 1};
        vecs[5]  = '{"slt_3_5",   4'b1000, 32'd3,         32'd5,          32'd1,          1'b0, 1'b0, 1};
        vecs[6]  = '{"slt_5_3",   4'b1000, 32'd5,         32'd3,          32'd0,          1'b1, 1'b0, 1};
        vecs[7]  = '{"sub_wrap",  4'b0010, 32'd0,         32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1};
        vecs[8]  = '{"mul_max",   4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1,          1'b0, 1'b0, 33};
        vecs[9]  = '{"div_by1",   4'b0100, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 33};
        vecs[10] = '{"div_small", 4'b0100, 32'd5,         32'd7,          32'd0,          1'b1, 1'b0, 33};
        vecs[11] = '{"nor_zero",  4'b0111, 32'd0,         32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1};
        vecs[12] = '{"sel_1111",  4'b1111, 32'd1,         32'd1,          32'd0,          1'b1, 1'b0, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready",    64'(in_ready),    64'd1);
        check("reset.out_valid",   64'(out_valid),   64'd0);
        check("reset.Res",         64'(Res),         64'd0);
        check("reset.zero_flag",   64'(zero_flag),   64'd0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_check(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].zf, vecs[i].dbz, vecs[i].lat);
        end

        // Sel sweep against the model
        for (int i = 0; i < 16; i++) begin
            s = 4'(i);
            model(s, 32'hF0F0_F0F0, 32'h0FF0_0FF0, r, zf, dbz, lat);
            run_check($sformatf("sweep_%0d", i), s, 32'hF0F0_F0F0, 32'h0FF0_0FF0, r, zf, dbz, lat);
        end

        // Back-pressure: result holds, in_ready low, held in_valid ignored until release
        @(negedge clk);
        A = 32'd3; B = 32'd5; Sel = OP_SLT; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp.first_valid", 64'(out_valid), 64'd1);
        A = 32'd1; B = 32'd2; Sel = OP_ADD;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.hold_res",   64'(Res),       64'd1);
            check("bp.in_ready",   64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release", {62'd0, out_valid, in_ready}, 64'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.second_valid", 64'(out_valid), 64'd1);
        check("bp.second_res",   64'(Res),       64'd3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk);
        A = 32'h0001_0000; B = 32'h0001_0001; Sel = OP_MUL; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midmul.in_ready",  64'(in_ready),  64'd0);
        check("midmul.out_valid", 64'(out_valid), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        check("rstmul.out_valid", 64'(out_valid), 64'd0);
        check("rstmul.Res",       64'(Res),       64'd0);
        check("rstmul.in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        run_check("after_rst_mul", OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33);

        // Randomized ops against the model
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: s = OP_MUL;
                1: s = OP_DIV;
                default: s = 4'($urandom_range(0, 15));
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 3));
                1: b = 32'($urandom_range(0, 65535));
                default: b = $urandom;
            endcase
            model(s, a, b, r, zf, dbz, lat);
            run_check($sformatf("rand_%0d_sel%0d", i, s), s, a, b, r, zf, dbz, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
